// File: rtl/ext_arbiter_pkg.sv
// Shared constants for the extension arbiter: FSM state encodings,
// source ids and datapath widths.
package ext_arbiter_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } arbState_t;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    localparam int IMM_W  = 16;
    localparam int DATA_W = 32;

endpackage

// File: rtl/ext_arbiter_signext.sv
// SignExtension: widens a 16-bit value to 32 bits, either by replicating
// bit 15 or by filling the upper half with zeros.
module SignExtension
    import ext_arbiter_pkg::*;
(
    input  logic [IMM_W-1:0]  immIn,
    input  logic              zeroExt,
    output logic [DATA_W-1:0] extOut
);

    always_comb begin
        extOut = {{(DATA_W-IMM_W){immIn[IMM_W-1] & ~zeroExt}}, immIn};
    end

endmodule

// File: rtl/ext_arbiter.sv
// Two-requester round-robin arbiter sharing one SignExtension unit; the
// granted operand is extended and registered for a ready/valid consumer.
module ext_arbiter
    import ext_arbiter_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              ReqA,
    input  logic [IMM_W-1:0]  InA,
    input  logic              ZeroExtA,
    input  logic              ReqB,
    input  logic [IMM_W-1:0]  InB,
    input  logic              ZeroExtB,
    output logic              GntA,
    output logic              GntB,
    output logic [DATA_W-1:0] Out,
    output logic              OutValid,
    output logic              OutSrc,
    input  logic              OutReady
);

    arbState_t         state;
    logic [DATA_W-1:0] outQ;
    logic              outSrcQ;
    logic              lastSrc;

    logic              free;
    logic              grant;
    logic              grantSrc;
    logic [IMM_W-1:0]  selIn;
    logic              selZero;
    logic [DATA_W-1:0] extOut;

    // B wins only if A is idle or A was the last one served; nothing is
    // granted while reset is held so no grant can vanish into a reset edge.
    always_comb begin
        free     = (state == EMPTY) || OutReady;
        GntB     = Reset && free && ReqB && (!ReqA || (lastSrc == SRC_A));
        GntA     = Reset && free && ReqA && !GntB;
        grant    = GntA || GntB;
        grantSrc = GntB ? SRC_B : SRC_A;
        selIn    = GntB ? InB : InA;
        selZero  = GntB ? ZeroExtB : ZeroExtA;
    end

    SignExtension uSignExt (
        .immIn   (selIn),
        .zeroExt (selZero),
        .extOut  (extOut)
    );

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state   <= EMPTY;
            outQ    <= '0;
            outSrcQ <= SRC_A;
            lastSrc <= SRC_B;
        end else begin
            if (grant) begin
                outQ    <= extOut;
                outSrcQ <= grantSrc;
                lastSrc <= grantSrc;
            end
            unique case (state)
                EMPTY: if (grant) state <= FULL;
                FULL:  if (OutReady && !grant) state <= EMPTY;
            endcase
        end
    end

    assign Out      = outQ;
    assign OutSrc   = outSrcQ;
    assign OutValid = (state == FULL);

endmodule
